// File: rtl/sram_word_bridge_if.sv
// Bus bundle between the load/store unit, the word bridge and the byte-wide sram_controller.
// The bridge takes the slave view; the core and the memory controller take the master view.
interface sram_word_bridge_if #(
   parameter int ADDR_W = 17
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic              resp_err;
   logic [31:0]       resp_rdata;
   logic              mem_trigger;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_busy;

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  mem_rdata, mem_busy,
      output req_ready, resp_valid, resp_err, resp_rdata,
      output mem_trigger, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output mem_rdata, mem_busy,
      input  req_ready, resp_valid, resp_err, resp_rdata,
      input  mem_trigger, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sram_word_bridge.sv
// Splits one aligned byte/half/word request into sequential byte transactions on the
// sram_controller trigger/busy port and assembles/extends load data little-endian.
module sram_word_bridge #(
   parameter int ADDR_W  = 17,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   sram_word_bridge_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_ARM   = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;
   logic [1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              req_bad;
   logic              last_byte;
   logic [1:0]        last_idx;
   logic [31:0]       load_ext;

   // Misalignment or size 11 is rejected at accept time; the SRAM is never touched.
   always_comb begin
      req_bad = 1'b0;
      case (bus.req_size)
         2'b00:   req_bad = 1'b0;
         2'b01:   req_bad = bus.req_addr[0];
         2'b10:   req_bad = (bus.req_addr[1:0] != 2'b00);
         default: req_bad = 1'b1;
      endcase
   end

   always_comb begin
      last_idx = 2'd0;
      case (size_q)
         2'b01:   last_idx = 2'd1;
         2'b10:   last_idx = 2'd3;
         default: last_idx = 2'd0;
      endcase
   end

   assign last_byte = (idx_q == last_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               rdata_d = '0;
               err_d   = req_bad;
               idx_d   = 2'd0;
               state_d = req_bad ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!bus.mem_busy) state_d = S_ARM;
         end
         S_ARM: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!bus.mem_busy) begin
               if (!we_q) rdata_d[{idx_q, 3'b000} +: 8] = bus.mem_rdata;
               if (last_byte) begin
                  state_d = S_RESP;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_ISSUE;
               end
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      load_ext = rdata_q;
      case (size_q)
         2'b00:   load_ext = {{24{~uns_q & rdata_q[7]}}, rdata_q[7:0]};
         2'b01:   load_ext = {{16{~uns_q & rdata_q[15]}}, rdata_q[15:0]};
         default: load_ext = rdata_q;
      endcase
   end

   // Memory-side fields are only driven while a byte is in flight, so they read 0 when idle.
   always_comb begin
      bus.req_ready   = (state_q == S_IDLE);
      bus.resp_valid  = (state_q == S_RESP);
      bus.resp_err    = (state_q == S_RESP) && err_q;
      bus.resp_rdata  = ((state_q == S_RESP) && !err_q && !we_q) ? load_ext : 32'h0;
      bus.mem_trigger = (state_q == S_ISSUE) && !bus.mem_busy;
      bus.mem_we      = 1'b0;
      bus.mem_addr    = '0;
      bus.mem_wdata   = 8'h00;
      if ((state_q == S_ISSUE) || (state_q == S_ARM) || (state_q == S_WAIT)) begin
         bus.mem_we    = we_q;
         bus.mem_addr  = addr_q + {{(ADDR_W-2){1'b0}}, idx_q};
         bus.mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
      end
   end
endmodule
